// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the ADC scan sequencer: default sizing parameters
// and the sequencer FSM state encoding.
//   NUM_CH_DEF      number of ADC channels scanned
//   DATA_W_DEF      ADC result width
//   TIMEOUT_CYC_DEF clk cycles to wait for adc_done before giving up
// ---------------------------------------------------------------------------
package adc_pkg;

    localparam int NUM_CH_DEF      = 8;
    localparam int DATA_W_DEF      = 12;
    localparam int TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // waiting for an accepted sample tick
        START = 2'd1,   // one-cycle adc_start pulse
        WAIT  = 2'd2,   // waiting for adc_done or timeout
        PUSH  = 2'd3    // holding a sample on the output stream
    } state_e;

endpackage

// File: rtl/adc_next_chan.sv
// ---------------------------------------------------------------------------
// adc_next_chan
// Combinational search for the lowest set mask bit strictly above a given
// channel index.
//   mask_i   channel mask to search
//   from_i   signed start index (CH_W+1 bits); all-ones (-1) searches from ch0
//   next_o   lowest set channel above from_i (0 when none)
//   found_o  a set channel above from_i exists
// ---------------------------------------------------------------------------
module adc_next_chan
    import adc_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W:0]     from_i,
    output logic [CH_W-1:0]   next_o,
    output logic              found_o
);

    // Walk downwards so the lowest qualifying channel is written last.
    always_comb begin
        next_o  = '0;
        found_o = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (i > int'($signed(from_i)))) begin
                next_o  = CH_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// ---------------------------------------------------------------------------
// adc_scan_sequencer
// Walks the channels selected by chan_mask once per accepted sample tick,
// starting a conversion on each, waiting for the ADC (with timeout), and
// streaming each result out through a valid/ready handshake.
//   clk, rst_n              clock, async active-low reset
//   sample_tick             scan-rate enable pulse
//   enable                  scanning permitted
//   chan_mask               channels to include in the next scan
//   clear_err               clears the sticky error flags
//   adc_start / adc_chan    conversion start pulse and channel
//   adc_done / adc_data     conversion complete pulse and result
//   sample_valid/ready      output stream handshake
//   sample_data/chan        result and its channel
//   scan_done               one-cycle end-of-scan pulse
//   overrun, timeout_err    sticky error flags
// ---------------------------------------------------------------------------
module adc_scan_sequencer
    import adc_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_tick,
    input  logic              enable,
    input  logic [NUM_CH-1:0] chan_mask,
    input  logic              clear_err,
    output logic              adc_start,
    output logic [CH_W-1:0]   adc_chan,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic [DATA_W-1:0] sample_data,
    output logic [CH_W-1:0]   sample_chan,
    output logic              scan_done,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   schan_q, schan_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              tmo_q, tmo_d;

    logic              advance;
    logic              tmo_set;
    logic              ovr_set;

    logic [NUM_CH-1:0] nc_mask;
    logic [CH_W:0]     nc_from;
    logic [CH_W-1:0]   nc_next;
    logic              nc_found;

    // In IDLE the search runs on the live mask from -1 (first channel);
    // mid-scan it runs on the latched mask above the current channel, so
    // chan_mask changes cannot disturb a scan in progress.
    always_comb begin
        if (state_q == IDLE) begin
            nc_mask = chan_mask;
            nc_from = '1;
        end else begin
            nc_mask = mask_q;
            nc_from = {1'b0, chan_q};
        end
    end

    adc_next_chan #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_next_chan (
        .mask_i  (nc_mask),
        .from_i  (nc_from),
        .next_o  (nc_next),
        .found_o (nc_found)
    );

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        chan_d  = chan_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        schan_d = schan_q;
        done_d  = 1'b0;
        advance = 1'b0;
        tmo_set = 1'b0;

        case (state_q)
            IDLE: begin
                if (sample_tick && enable && nc_found) begin
                    mask_d  = chan_mask;
                    chan_d  = nc_next;
                    state_d = START;
                end
            end
            START: begin
                // adc_done here belongs to nothing we started; ignore it.
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (adc_done) begin
                    data_d  = adc_data;
                    schan_d = chan_q;
                    state_d = PUSH;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // TIMEOUT_CYC wait cycles elapsed: skip this channel.
                    tmo_set = 1'b1;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PUSH: begin
                if (sample_ready) begin
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Move on to the next latched channel, or finish the scan.
        if (advance) begin
            if (nc_found && enable) begin
                chan_d  = nc_next;
                state_d = START;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // Sticky flags: a set event in the same cycle beats clear_err.
        ovr_set = sample_tick && (state_q != IDLE);
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clear_err) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
        if (tmo_set) begin
            tmo_d = 1'b1;
        end else if (clear_err) begin
            tmo_d = 1'b0;
        end else begin
            tmo_d = tmo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            chan_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            schan_q <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            schan_q <= schan_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign adc_start    = (state_q == START);
    assign adc_chan     = chan_q;
    assign sample_valid = (state_q == PUSH);
    assign sample_data  = data_q;
    assign sample_chan  = schan_q;
    assign scan_done    = done_q;
    assign overrun      = ovr_q;
    assign timeout_err  = tmo_q;

endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter NUM_CH, default 8: number of ADC channels; channel index width CH_W = clog2(NUM_CH) = 3.
REQ-002 Parameter DATA_W, default 12: ADC result width.
REQ-003 Parameter TIMEOUT_CYC, default 1024: maximum clk cycles to wait for adc_done.
REQ-004 clk  in  1  system clock, 100 MHz, all logic on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 sample_tick  in  1  one-cycle sample-rate enable from the ADC clock divider (33.33 kHz).
REQ-007 enable  in  1  scanning permitted when high.
REQ-008 chan_mask  in  NUM_CH  bit i set = channel i included in scan.
REQ-009 clear_err  in  1  one-cycle pulse clearing sticky error flags.
REQ-010 adc_start  out  1  one-cycle conversion start pulse to ADC.
REQ-011 adc_chan  out  CH_W  channel under conversion, valid while adc_start high and throughout the wait.
REQ-012 adc_done  in  1  one-cycle conversion-complete pulse.
REQ-013 adc_data  in  DATA_W  result, valid when adc_done high.
REQ-014 sample_valid / sample_ready  out / in  1 / 1  output stream handshake.
REQ-015 sample_data, sample_chan, scan_done, overrun, timeout_err  out  DATA_W, CH_W, 1, 1, 1  result, its channel, end-of-scan pulse, sticky errors.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT, PUSH.
REQ-017 IDLE: sample_tick=1 with enable=1 and chan_mask!=0 SHALL latch chan_mask, select its lowest set bit, and enter START; otherwise the FSM SHALL remain in IDLE.
REQ-018 adc_start SHALL be high exactly in the cycle after the accepted tick (START, one cycle); the FSM SHALL then enter WAIT.
REQ-019 adc_done in the START cycle SHALL be ignored.
REQ-020 In WAIT, adc_done=1 SHALL capture adc_data and adc_chan into sample_data and sample_chan and enter PUSH.
REQ-021 sample_valid SHALL rise the cycle after adc_done.
REQ-022 PUSH: sample_valid SHALL be held with sample_data and sample_chan stable until sample_ready=1.
REQ-023 On the handshake cycle, if a higher latched channel remains and enable=1, the FSM SHALL go to START, so that the next adc_start occurs at handshake+1.
REQ-024 On the handshake cycle, if no higher latched channel remains or enable=0, the FSM SHALL go to IDLE and pulse scan_done for one cycle.
REQ-025 WAIT cycle counter SHALL reset on START.
REQ-026 If the WAIT counter reaches TIMEOUT_CYC without adc_done, the block SHALL set timeout_err, produce no sample for that channel, and advance as in REQ-023/024 (scan_done if last).
REQ-027 sample_tick in any state other than IDLE SHALL be dropped and SHALL set overrun, including a tick in the final handshake cycle.
REQ-028 chan_mask changes mid-scan SHALL have no effect until the next scan.
REQ-029 enable falling mid-scan SHALL let the current conversion and push complete, then return to IDLE.
REQ-030 clear_err SHALL clear overrun and timeout_err; a simultaneous set event SHALL win.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, adc_start=0, adc_chan=0, sample_valid=0, sample_data=0, sample_chan=0, scan_done=0, overrun=0, timeout_err=0, WAIT counter=0, latched mask=0.
REQ-032 Reset asserted mid-scan SHALL abandon the conversion; adc_done arriving after reset release SHALL be ignored in IDLE.

Structure
REQ-033 Package adc_pkg SHALL hold the FSM state enum and the NUM_CH, DATA_W, and TIMEOUT_CYC defaults.
REQ-034 One combinational sub-module adc_next_chan SHALL return the lowest set mask bit strictly above a given index, plus a found flag (index -1 encoding for the first channel).

Verification
REQ-035 mask=8'b0000_0101, ready=1, ADC done 10 cycles after start with data 0x123 then 0x456 -> samples (ch0,0x123),(ch2,0x456); scan_done pulse; adc_start at tick+1 and handshake+1.
REQ-036 mask=8'h01, sample_ready held low 50 cycles -> sample_valid and data stable for 50 cycles; no adc_start until handshake.
REQ-037 Second tick during WAIT -> overrun=1; scan unaffected; clear_err then clears overrun.
REQ-038 mask=8'h03, ADC never answers ch0 -> timeout_err=1 after 1024 WAIT cycles; no ch0 sample; ch1 converted normally.
REQ-039 rst_n pulsed low during WAIT, then a late adc_done -> all outputs at reset values; no sample emitted.
REQ-040 mask=0 or enable=0 with ticks -> no adc_start and no flag changes.
